mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Holds at most one memory transaction in flight. It sequences each transaction as request, accept and response, then routes the response back to the requester that owns it.
- Data accesses have priority over fetches. A streak limit stops fetch from being starved.
- Adds a response timeout with an error pulse, so a dead memory cannot hang the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, number of consecutive data grants allowed while if_req is waiting before fetch is forced to win. Must be 1 to 15.
- TIMEOUT_CYC, 16, maximum number of WAIT cycles for a read response. Must be 2 to 255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request captured.
- if_rvalid  out  1  one-cycle pulse: fetch response on if_rdata.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request.
- dm_we  in  1  data write enable.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  one-cycle pulse: data request captured.
- dm_rvalid  out  1  one-cycle pulse: data transaction done (load data, or write acknowledge).
- dm_rdata  out  DATA_W  load data; 0 for writes.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- bus_err  out  1  one-cycle pulse: read timed out.

Behaviour:
- Outputs and clock:
  - Every output is registered.
  - rst low clears all outputs, the state, the owner, the streak counter and the timeout counter to 0, and forces state IDLE.
  - Reset asserted mid-transaction abandons the transaction; no rvalid is ever produced for it.
- State IDLE:
  - Arbitration happens at each edge where the state is IDLE and dm_req or if_req is high.
  - Winner is data, unless if_req=1 and streak==MAX_DM_STREAK, in which case fetch wins.
  - On a win: latch the winner's addr, we and wdata into mem_* (fetch sets we=0); set mem_req=1; pulse the winner's gnt; record the owner; go to ISSUE.
  - A requester may drop req after gnt. Inputs are not sampled outside IDLE.
- Streak counter:
  - Increments, saturating at MAX_DM_STREAK, on a data grant while if_req=1.
  - Clears on any fetch grant, and on a data grant while if_req=0.
- State ISSUE:
  - Hold mem_req=1 and the latched fields until mem_ready=1. There is no timeout in ISSUE.
  - On mem_ready, write: clear mem_req; pulse dm_rvalid with dm_rdata=0 next cycle; go to IDLE.
  - On mem_ready, read: clear mem_req; clear the timeout counter; go to WAIT.
- State WAIT:
  - mem_req=0. The timeout counter increments each cycle.
  - On mem_rvalid=1: the owner's rvalid pulses next cycle with rdata=mem_rdata; go to IDLE.
  - If the counter reaches TIMEOUT_CYC-1 with mem_rvalid=0: the owner's rvalid and bus_err pulse next cycle with rdata=0; go to IDLE.
  - If mem_rvalid arrives in the expiry cycle, the real data wins and bus_err stays 0.
- mem_rvalid while in IDLE or ISSUE is ignored.
- rdata outputs hold their value between pulses; the non-owner's rdata is unchanged.
- Latency, best case:
  - Read: req sampled at edge 0; gnt and mem_req high in cycle 1; mem_ready in cycle 1; WAIT in cycle 2; mem_rvalid in cycle 2; rvalid in cycle 3.
  - The state is IDLE in cycle 3, so the next grant is in cycle 4.
  - Write: ack in cycle 2.
- Simultaneous requests in IDLE: exactly one gnt is pulsed. The loser keeps its req high and is re-arbitrated after the current transaction completes.

Test Plan:
- Fetch alone, if_addr=0x100, mem_ready=1 immediately, mem_rvalid=1 one cycle later with 0xDEADBEEF → if_gnt in cycle 1; if_rvalid in cycle 3 with if_rdata=0xDEADBEEF; dm_* outputs stay 0.
- Store dm_we=1, addr=0x2000, wdata=0x55, mem_ready delayed 3 cycles → mem_req held 3 cycles with stable fields; dm_rvalid one cycle after accept with dm_rdata=0.
- if_req and dm_req held high continuously, MAX_DM_STREAK=4 → grant order D,D,D,D,F,D,D,D,D,F.
- Read with mem_rvalid never asserted, TIMEOUT_CYC=16 → owner rvalid and bus_err pulse together after 16 WAIT cycles with rdata=0; the next request is then granted normally.
- mem_rvalid in the expiry cycle with data 0x1234 → rvalid with 0x1234; bus_err=0.
- rst pulled low while in WAIT, then released, then mem_rvalid arrives → no rvalid; all outputs 0; a new if_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its two requesters (fetch and
// load/store) and the single-ported memory behind it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_err;

  // Environment side: requesters plus memory model.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one transaction in flight, data priority with a fetch anti-starvation streak.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT_CYC   = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        tmo_q, tmo_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              bus_err_q, bus_err_d;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= 4'd0;
      tmo_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state logic: arbitration in IDLE, memory handshake in ISSUE, response/timeout in WAIT.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req && (!bus.dm_req || (streak_q == STREAK_MAX))) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = {DATA_W{1'b0}};
          if_gnt_d    = 1'b1;
          streak_d    = 4'd0;
          state_d     = ISSUE;
        end else if (bus.dm_req) begin
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          dm_gnt_d    = 1'b1;
          // Only a waiting fetch makes consecutive data grants count as a streak.
          if (!bus.if_req) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end else begin
            streak_d = streak_q;
          end
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = {DATA_W{1'b0}};
            state_d     = IDLE;
          end else begin
            tmo_d   = 8'd0;
            state_d = WAIT;
          end
        end else begin
          state_d = ISSUE;
        end
      end

      WAIT: begin
        // Real data takes precedence even in the expiry cycle.
        if (bus.mem_rvalid) begin
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = {DATA_W{1'b0}};
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = {DATA_W{1'b0}};
          end
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d   = tmo_q + 8'd1;
          state_d = WAIT;
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: single transactions from a
// vector table, plus hand sequences for streak fairness and mid-transaction reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_if_rdata = 32'd0;
  logic [31:0] last_dm_rdata = 32'd0;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_dly;  // cycles mem_ready is held low after the grant
    logic        stray;      // drive mem_rvalid while still in ISSUE
    int          rv_dly;     // WAIT cycle index at which mem_rvalid is driven (>=16: never)
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // WAIT cycle index at which the owner's rvalid is seen
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic        seen;
    int          lat;
    logic [31:0] got_data;
    logic        got_err;
    logic        other_rv;
    logic [31:0] other_rd;
    logic        exp_we;

    exp_we = v.is_dm & v.we;
    if (v.is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    @(negedge clk);
    chk("gnt_owner", 32'(v.is_dm ? bus.dm_gnt : bus.if_gnt), 32'd1);
    chk("gnt_other", 32'(v.is_dm ? bus.if_gnt : bus.dm_gnt), 32'd0);
    chk("mem_req_issue", 32'(bus.mem_req), 32'd1);
    chk("mem_addr", bus.mem_addr, v.addr);
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (v.is_dm) chk("mem_wdata", bus.mem_wdata, v.wdata);
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;

    bus.mem_ready = (v.ready_dly == 0);
    bus.mem_rvalid = v.stray; bus.mem_rdata = 32'hBAD0BAD0;
    for (int k = 0; k < v.ready_dly; k++) begin
      @(negedge clk);
      chk("hold_mem_req", 32'(bus.mem_req), 32'd1);
      chk("hold_addr", bus.mem_addr, v.addr);
      chk("hold_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'd0);
      bus.mem_ready = (k == v.ready_dly - 1);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    chk("mem_req_drop", 32'(bus.mem_req), 32'd0);

    if (exp_we) begin
      chk("wr_ack", 32'(bus.dm_rvalid), 32'd1);
      chk("wr_rdata", bus.dm_rdata, 32'd0);
      chk("wr_if_quiet", 32'(bus.if_rvalid), 32'd0);
      chk("wr_if_rdata", bus.if_rdata, last_if_rdata);
      last_dm_rdata = 32'd0;
    end else begin
      seen = 1'b0; lat = -1; got_data = 32'd0; got_err = 1'b0; other_rv = 1'b0; other_rd = 32'd0;
      for (int idx = 0; idx < 40 && !seen; idx++) begin
        if (v.is_dm ? bus.dm_rvalid : bus.if_rvalid) begin
          seen     = 1'b1;
          lat      = idx;
          got_data = v.is_dm ? bus.dm_rdata : bus.if_rdata;
          got_err  = bus.bus_err;
          other_rv = v.is_dm ? bus.if_rvalid : bus.dm_rvalid;
          other_rd = v.is_dm ? bus.if_rdata : bus.dm_rdata;
        end else begin
          chk("early_err", 32'(bus.bus_err), 32'd0);
          bus.mem_rvalid = (idx == v.rv_dly);
          bus.mem_rdata  = (idx == v.rv_dly) ? v.mrdata : 32'hBAD1BAD1;
          @(negedge clk);
        end
      end
      bus.mem_rvalid = 1'b0;
      chk("rvalid_seen", 32'(seen), 32'd1);
      chk("rvalid_lat", lat, v.exp_lat);
      chk("rdata", got_data, v.exp_rdata);
      chk("bus_err", 32'(got_err), 32'(v.exp_err));
      chk("other_rvalid", 32'(other_rv), 32'd0);
      chk("other_rdata", other_rd, v.is_dm ? last_if_rdata : last_dm_rdata);
      if (v.is_dm) last_dm_rdata = v.exp_rdata;
      else         last_if_rdata = v.exp_rdata;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, 32'({bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid,
                               bus.mem_req, bus.mem_we, bus.bus_err}), 32'd0);
    chk({name, "_addr"}, bus.mem_addr, 32'd0);
    chk({name, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({name, "_dm_rdata"}, bus.dm_rdata, 32'd0);
  endtask

  logic [9:0] exp_order;
  int         n_gnt;
  vec_t       post_rst;

  initial begin
    //            is_dm we    addr          wdata         rdy stray rv  mrdata        exp_rdata     err   lat
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        0, 1'b0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h55,       3, 1'b0, 0,  32'h0,        32'h0,        1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        1, 1'b0, 2,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        0, 1'b0, 99, 32'h0,        32'h0,        1'b1, 16};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        0, 1'b0, 15, 32'h0000_1234, 32'h0000_1234, 1'b0, 16};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        2, 1'b1, 1,  32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 2};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0,        0, 1'b0, 14, 32'h0000_0077, 32'h0000_0077, 1'b0, 15};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0044, 32'hA5A5A5A5, 0, 1'b0, 0,  32'h0,        32'h0,        1'b0, 0};

    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Both requesters held high: data wins four times, then fetch is forced in.
    exp_order = 10'b01_1110_1111;
    n_gnt = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h500; bus.dm_wdata = 32'h1;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600;
    for (int c = 0; c < 200 && n_gnt < 10; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.dm_gnt) begin
        chk("single_gnt", 32'(bus.if_gnt & bus.dm_gnt), 32'd0);
        chk($sformatf("order_%0d", n_gnt), 32'(bus.dm_gnt), 32'(exp_order[n_gnt]));
        n_gnt++;
      end
    end
    chk("order_count", n_gnt, 32'd10);
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    repeat (4) @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    @(negedge clk);

    // Reset while WAITing for a fetch response: the late response must vanish.
    bus.if_req = 1'b1; bus.if_addr = 32'h700; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_seq_gnt", 32'(bus.if_gnt), 32'd1);
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFEEDFACE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk("post_rst_quiet", 32'({bus.if_rvalid, bus.dm_rvalid, bus.bus_err, bus.mem_req}), 32'd0);
      chk("post_rst_rdata", bus.if_rdata, 32'd0);
    end
    last_if_rdata = 32'd0;
    last_dm_rdata = 32'd0;
    post_rst = '{1'b0, 1'b0, 32'h0000_0800, 32'h0, 0, 1'b0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1};
    run_txn(post_rst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
